// File: rtl/tpx3_tx_serializer.sv
// Timepix3 slow-control transmit serializer: shifts a programmable number of
// buffered bits MSB-first onto the chip DataIn line, framed by TX_EN.
module tpx3_tx_serializer #(
  parameter int MEM_ABITS  = 8,
  parameter int CLK_DIV    = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 MEM_WR,
  input  logic [MEM_ABITS-1:0] MEM_ADD,
  input  logic [7:0]           MEM_DATA,
  input  logic                 START,
  input  logic [MEM_ABITS+3:0] SIZE,
  output logic                 TX_DATA,
  output logic                 TX_EN,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int SW = MEM_ABITS + 4;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [SW-1:0] MAX_BITS = SW'(8 << MEM_ABITS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE_ST} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             mem [0:(1<<MEM_ABITS)-1];
  logic [7:0]             shreg;
  logic [SW-1:0]          bit_cnt, size_q, size_c;
  logic [DW-1:0]          div_cnt;
  logic [MEM_ABITS-1:0]   addr, rd_addr;
  logic                   bit_end, last_bit, load_byte, shift_bit, accept;

  assign size_c   = (SIZE > MAX_BITS) ? MAX_BITS : SIZE;
  assign bit_end  = (div_cnt == DW'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == size_q - SW'(1));
  // LOAD fetches byte 0; later fetches look one byte ahead so the next byte
  // lands in the shift register on the same edge bit 7 finishes.
  assign rd_addr  = (state == LOAD) ? addr : addr + MEM_ABITS'(1);

  always_comb begin
    state_nxt = state;
    load_byte = 1'b0;
    shift_bit = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: if (START) begin
        accept    = 1'b1;
        state_nxt = (size_c == '0) ? DONE_ST : LOAD;
      end
      LOAD: begin
        load_byte = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (bit_end) begin
        if (last_bit)                  state_nxt = DONE_ST;
        else if (bit_cnt[2:0] == 3'd7) load_byte = 1'b1;
        else                           shift_bit = 1'b1;
      end
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer and shift register are not reset; writes only land while idle.
  always_ff @(posedge BUS_CLK) begin
    if (MEM_WR && state == IDLE) mem[MEM_ADD] <= MEM_DATA;
    if (load_byte)      shreg <= mem[rd_addr];
    else if (shift_bit) shreg <= {shreg[6:0], 1'b0};
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      addr    <= '0;
      size_q  <= '0;
      TX_DATA <= IDLE_LEVEL;
      TX_EN   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != IDLE);
      DONE  <= (state_nxt == DONE_ST);
      TX_EN <= (state_nxt == SHIFT);

      if (load_byte)               TX_DATA <= mem[rd_addr][7];
      else if (shift_bit)          TX_DATA <= shreg[6];
      else if (state_nxt != SHIFT) TX_DATA <= IDLE_LEVEL;

      if (accept) begin
        size_q  <= size_c;
        bit_cnt <= '0;
        addr    <= '0;
        div_cnt <= '0;
      end

      if (state == SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          if (!last_bit) begin
            bit_cnt <= bit_cnt + SW'(1);
            if (bit_cnt[2:0] == 3'd7) addr <= addr + MEM_ABITS'(1);
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tpx3_tx_serializer.sv
// Bench for tpx3_tx_serializer: two configurations share stimulus, a
// per-cycle waveform model built from the bit-stream rules checks both.
module tb_tpx3_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n, mem_wr, start;
  logic [7:0]  mem_add, mem_data;
  logic [11:0] size;
  logic        txd_a, txe_a, busy_a, done_a;
  logic        txd_b, txe_b, busy_b, done_b;

  always #5 clk = ~clk;

  tpx3_tx_serializer #(.MEM_ABITS(8), .CLK_DIV(1), .IDLE_LEVEL(1'b0)) dut_a (
    .BUS_CLK(clk), .BUS_RST(rst_n), .MEM_WR(mem_wr), .MEM_ADD(mem_add),
    .MEM_DATA(mem_data), .START(start), .SIZE(size),
    .TX_DATA(txd_a), .TX_EN(txe_a), .BUSY(busy_a), .DONE(done_a));

  tpx3_tx_serializer #(.MEM_ABITS(2), .CLK_DIV(3), .IDLE_LEVEL(1'b1)) dut_b (
    .BUS_CLK(clk), .BUS_RST(rst_n), .MEM_WR(mem_wr), .MEM_ADD(mem_add[1:0]),
    .MEM_DATA(mem_data), .START(start), .SIZE(size[5:0]),
    .TX_DATA(txd_b), .TX_EN(txe_b), .BUSY(busy_b), .DONE(done_b));

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Expected outputs per cycle, packed as {tx_data, tx_en, busy, done}.
  logic [3:0] cur [2] = '{4'b0000, 4'b1000};
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [7:0] ma [256];
  logic [7:0] mb [4];

  function automatic logic [3:0] idle_val(input int d);
    return {d == 1, 3'b000};
  endfunction

  task automatic push(input int d, input logic [3:0] e);
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  // Whole transfer waveform from the stream rule bit k = MEM[k>>3][7-(k&7)].
  task automatic build(input int d, input int sz);
    int cap, n, div;
    logic idl;
    logic [7:0] b;
    cap = (d == 0) ? 2048 : 32;
    div = (d == 0) ? 1 : 3;
    idl = (d == 1);
    n   = (sz > cap) ? cap : sz;
    if (n == 0) begin
      push(d, {idl, 3'b011});
    end else begin
      push(d, {idl, 3'b010});
      for (int k = 0; k < n; k++) begin
        b = (d == 0) ? ma[k >> 3] : mb[(k >> 3) % 4];
        for (int r = 0; r < div; r++) push(d, {b[7 - (k % 8)], 3'b110});
      end
      push(d, {idl, 3'b011});
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wr && !cur[d][1]) begin
        if (d == 0) ma[mem_add] = mem_data; else mb[mem_add[1:0]] = mem_data;
      end
      if (!rst_n) begin
        if (d == 0) qa.delete(); else qb.delete();
        cur[d] = idle_val(d);
      end else begin
        if (start && !cur[d][1]) build(d, (d == 0) ? int'(size) : int'(size[5:0]));
        if (d == 0) cur[0] = (qa.size() > 0) ? qa.pop_front() : idle_val(0);
        else        cur[1] = (qb.size() > 0) ? qb.pop_front() : idle_val(1);
      end
    end
    if (!rst_n) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      nvec += 2;
      if ({txd_a, txe_a, busy_a, done_a} !== cur[0]) begin
        nerr++;
        $display("FAIL cycle_a t=%0t got %b expected %b", $time, {txd_a, txe_a, busy_a, done_a}, cur[0]);
      end
      if ({txd_b, txe_b, busy_b, done_b} !== cur[1]) begin
        nerr++;
        $display("FAIL cycle_b t=%0t got %b expected %b", $time, {txd_b, txe_b, busy_b, done_b}, cur[1]);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] dt);
    @(posedge clk); #1;
    mem_wr = 1'b1; mem_add = 8'(a); mem_data = dt;
    @(posedge clk); #1;
    mem_wr = 1'b0;
  endtask

  // Returns one time unit after edge 0, i.e. inside cycle 1.
  task automatic start_xfer(input int sz);
    @(posedge clk); #1;
    start = 1'b1; size = 12'(sz);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_a || busy_b) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) begin
      nvec++; nerr++;
      $display("FAIL wait_idle: busy still %b%b after 3000 cycles", busy_a, busy_b);
    end
  endtask

  task automatic run_a16(input bit inject, output logic [15:0] bits);
    int en_n = 0;
    bits = '0;
    start_xfer(16);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 17) begin
        bits = {bits[14:0], txd_a};
        en_n += int'(txe_a);
      end
      if (c == 18) check("done_at_18", 64'({done_a, busy_a, txe_a}), 64'(3'b110));
      if (c == 19) check("idle_at_19", 64'({busy_a, done_a}), 64'(2'b00));
      if (inject && c == 5) begin
        start = 1'b1; size = 12'd8; mem_wr = 1'b1; mem_add = 8'd1; mem_data = 8'hFF;
      end
      if (inject && c == 6) begin
        start = 1'b0; mem_wr = 1'b0;
      end
    end
    check("en_count16", 64'(en_n), 64'd16);
  endtask

  initial begin
    logic [15:0] bits16;
    logic [63:0] bits;
    int n, runs, dones;
    logic prev;

    rst_n = 1'b0; start = 1'b1; size = 12'd16;
    mem_wr = 1'b0; mem_add = '0; mem_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_a", 64'({txd_a, txe_a, busy_a, done_a}), 64'(4'b0000));
      check("reset_b", 64'({txd_b, txe_b, busy_b, done_b}), 64'(4'b1000));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;

    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      mem_wr = 1'b1; mem_add = 8'(i); mem_data = 8'($urandom);
    end
    @(posedge clk); #1;
    mem_wr = 1'b0;

    wr(0, 8'hA5); wr(1, 8'h3C);
    run_a16(1'b0, bits16);
    check("basic_bits", 64'(bits16), 64'(16'b1010010100111100));
    wait_idle();

    start_xfer(0);
    @(negedge clk);
    check("zero_c1", 64'({txe_a, busy_a, done_a, txe_b, busy_b, done_b}), 64'(6'b011011));
    @(negedge clk);
    check("zero_c2", 64'({busy_a, done_a, busy_b, done_b}), 64'(4'b0000));
    wait_idle();

    run_a16(1'b1, bits16);
    check("ignored_start_bits", 64'(bits16), 64'(16'hA53C));
    wait_idle();

    wr(0, 8'hF0);
    start_xfer(5);
    bits = '0; bits16 = '0; n = 0; dones = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (txe_b) begin bits = {bits[62:0], txd_b}; n++; end
      if (txe_a) bits16 = {bits16[14:0], txd_a};
      dones += int'(done_b);
    end
    check("partial_b_len", 64'(n), 64'd15);
    check("partial_b_bits", bits, 64'(15'b111111111111000));
    check("partial_a_bits", 64'(bits16), 64'(5'b11110));
    check("partial_b_done", 64'(dones), 64'd1);
    wait_idle();

    for (int i = 0; i < 4; i++) wr(i, 8'h81);
    start_xfer(63);
    bits = '0; n = 0; runs = 0; prev = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (txe_b) begin
        if (n % 3 == 0) bits = {bits[62:0], txd_b};
        n++;
      end
      if (txe_b && !prev) runs++;
      prev = txe_b;
    end
    check("wrap_b_len", 64'(n), 64'd96);
    check("wrap_b_bits", bits, 64'h0000_0000_8181_8181);
    check("wrap_b_runs", 64'(runs), 64'd1);
    wait_idle();

    wr(0, 8'hA5); wr(1, 8'h3C);
    start_xfer(16);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 8) rst_n = 1'b0;
      if (c == 9) begin
        check("midreset_a", 64'({txd_a, txe_a, busy_a, done_a}), 64'(4'b0000));
        check("midreset_b", 64'({txd_b, txe_b, busy_b, done_b}), 64'(4'b1000));
        rst_n = 1'b1;
      end
    end
    repeat (3) @(negedge clk);
    run_a16(1'b0, bits16);
    check("after_reset_bits", 64'(bits16), 64'(16'hA53C));
    wait_idle();

    for (int i = 0; i < 4000; i++) begin
      int r;
      @(posedge clk); #1;
      rst_n    = ($urandom % 400) != 0;
      mem_wr   = ($urandom % 5) == 0;
      mem_add  = 8'($urandom);
      mem_data = 8'($urandom);
      start    = ($urandom % 10) == 0;
      r = int'($urandom % 20);
      if (r == 0)      size = 12'd0;
      else if (r == 1) size = 12'($urandom_range(60, 70));
      else if (r == 2) size = 12'($urandom_range(2040, 2060));
      else             size = 12'($urandom_range(1, 40));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_wr = 1'b0; start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
